snake_control: RTL and testbench

- Upstream sequencer for the snake `datapath`. Generates every control strobe that block consumes: ld_head, ld_q_def, inc_address, rst_address, draw_q, cnt_status, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, waiting, dir.
- Also decodes the four direction buttons into dir, paces moves with a frame timer, selects plot colour for the VGA adapter, and halts the game on isDead.

---
 rtl/snake_control_if.sv | 51 +++++
 rtl/snake_control.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_snake_control.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/snake_control_if.sv
// ============================================================================
// snake_control_if : control bus between the snake sequencer and datapath
// Revision 1.0
// ============================================================================
`default_nettype none

interface snake_control_if;
  logic        start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        isDead;
  logic [10:0] length;

  logic        waiting;
  logic        ld_head;
  logic        ld_q_def;
  logic        inc_address;
  logic        rst_address;
  logic        draw_q;
  logic        draw_curr;
  logic        update_head;
  logic        ld_head_into_prev;
  logic        ld_q_into_curr;
  logic        ld_prev_into_q;
  logic        ld_curr_into_prev;
  logic        food_en;
  logic [1:0]  cnt_status;
  logic [2:0]  dir;
  logic [2:0]  colour;
  logic        dead;

  modport master (
    input  start, btn_up, btn_down, btn_left, btn_right, isDead, length,
    output waiting, ld_head, ld_q_def, inc_address, rst_address, draw_q,
           draw_curr, update_head, ld_head_into_prev, ld_q_into_curr,
           ld_prev_into_q, ld_curr_into_prev, food_en, cnt_status, dir,
           colour, dead
  );

  modport slave (
    output start, btn_up, btn_down, btn_left, btn_right, isDead, length,
    input  waiting, ld_head, ld_q_def, inc_address, rst_address, draw_q,
           draw_curr, update_head, ld_head_into_prev, ld_q_into_curr,
           ld_prev_into_q, ld_curr_into_prev, food_en, cnt_status, dir,
           colour, dead
  );
endinterface

`default_nettype wire

// File: rtl/snake_control.sv
// ============================================================================
// snake_control : move sequencer, direction decode and frame pacing for snake
// Revision 1.0
// ============================================================================
`default_nettype none

module snake_control #(
  parameter int FRAME_CYCLES = 5000000,
  parameter int CNT_W        = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  snake_control_if.master        bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT_H = 4'd1,
    INIT_W = 4'd2,
    INIT_E = 4'd3,
    WAIT   = 4'd4,
    ERASE  = 4'd5,
    UPDATE = 4'd6,
    SHIFT  = 4'd7,
    EAT    = 4'd8,
    DRAW   = 4'd9,
    DEAD   = 4'd10
  } state_t;

  typedef struct packed {
    logic       waiting;
    logic       ld_head;
    logic       ld_q_def;
    logic       inc_address;
    logic       rst_address;
    logic       draw_q;
    logic       update_head;
    logic       ld_head_into_prev;
    logic       ld_q_into_curr;
    logic       ld_prev_into_q;
    logic       ld_curr_into_prev;
    logic       food_en;
    logic       dead;
    logic [1:0] cnt_status;
    logic [2:0] colour;
  } ctl_t;

  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

  state_t           state_q, state_d;
  logic [10:0]      seg_q, seg_d;
  logic [10:0]      len_q, len_d;
  logic [2:0]       sub_q, sub_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [2:0]       dir_q, dir_d;
  logic [2:0]       pend_q, pend_d;
  ctl_t             out_q, out_d;

  logic [10:0]      len_in;
  logic [2:0]       req;
  logic             req_valid;
  logic             tail;

  assign len_in = (bus.length == 11'd0) ? 11'd1 : bus.length;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      seg_q   <= '0;
      len_q   <= 11'd1;
      sub_q   <= '0;
      frame_q <= '0;
      dir_q   <= DIR_UP;
      pend_q  <= DIR_UP;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      sub_q   <= sub_d;
      frame_q <= frame_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  // Same-axis requests that differ from the current heading are reversals.
  always_comb begin
    req       = pend_q;
    req_valid = 1'b1;
    if      (bus.btn_up)    req = DIR_UP;
    else if (bus.btn_down)  req = DIR_DOWN;
    else if (bus.btn_left)  req = DIR_LEFT;
    else if (bus.btn_right) req = DIR_RIGHT;
    else                    req_valid = 1'b0;

    pend_d = pend_q;
    if (state_q != IDLE && state_q != DEAD && req_valid &&
        (req[2] != dir_q[2] || req == dir_q))
      pend_d = req;
    dir_d = (state_q == WAIT) ? pend_d : dir_q;
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    len_d   = len_q;
    sub_d   = sub_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = INIT_H;
          seg_d   = '0;
          sub_d   = '0;
        end
      end
      INIT_H: begin
        state_d = INIT_W;
        len_d   = len_in;
        seg_d   = '0;
      end
      INIT_W: begin
        seg_d = seg_q + 11'd1;
        if (seg_q + 11'd1 == len_q) state_d = INIT_E;
      end
      INIT_E: begin
        state_d = DRAW;
        len_d   = len_in;
        seg_d   = '0;
        sub_d   = '0;
      end
      WAIT: begin
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          state_d = ERASE;
          len_d   = len_in;
          seg_d   = '0;
          sub_d   = '0;
        end else begin
          frame_d = frame_q + CNT_W'(1);
        end
      end
      ERASE, DRAW: begin
        if (seg_q != len_q) begin
          if (sub_q == 3'd4) begin
            sub_d = '0;
            seg_d = seg_q + 11'd1;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end else if (state_q == ERASE) begin
          state_d = UPDATE;
          seg_d   = '0;
          sub_d   = '0;
        end else if (sub_q == 3'd4) begin
          state_d = WAIT;
          seg_d   = '0;
          sub_d   = '0;
          frame_d = '0;
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      UPDATE: begin
        if (sub_q == 3'd1) begin
          state_d = SHIFT;
          len_d   = len_in;
          seg_d   = '0;
          sub_d   = '0;
        end else begin
          sub_d = 3'd1;
        end
      end
      SHIFT: begin
        if (seg_q != len_q) begin
          if (sub_q == 3'd3) begin
            sub_d = '0;
            seg_d = seg_q + 11'd1;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end else begin
          state_d = EAT;
          seg_d   = '0;
          sub_d   = '0;
        end
      end
      EAT: begin
        state_d = DRAW;
        len_d   = len_in;
        seg_d   = '0;
        sub_d   = '0;
      end
      default: state_d = DEAD;
    endcase
    if ((state_q == SHIFT || state_q == DRAW) && bus.isDead) state_d = DEAD;
  end

  // Outputs decode the upcoming state so each strobe lines up with its cycle.
  always_comb begin
    out_d = '0;
    tail  = (seg_d == len_d);
    case (state_d)
      INIT_H: begin
        out_d.ld_head     = 1'b1;
        out_d.rst_address = 1'b1;
      end
      INIT_W: begin
        out_d.ld_q_def    = 1'b1;
        out_d.inc_address = 1'b1;
      end
      INIT_E: out_d.rst_address = 1'b1;
      ERASE, DRAW: begin
        if (!tail) begin
          if (sub_d != 3'd0) begin
            out_d.draw_q      = 1'b1;
            out_d.inc_address = (sub_d == 3'd4);
            out_d.colour      = (state_d == DRAW) ? 3'b010 : 3'b000;
            case (sub_d)
              3'd1:    out_d.cnt_status = 2'b00;
              3'd2:    out_d.cnt_status = 2'b01;
              3'd3:    out_d.cnt_status = 2'b10;
              default: out_d.cnt_status = 2'b11;
            endcase
          end
        end else if (state_d == DRAW && sub_d != 3'd4) begin
          out_d.food_en    = 1'b1;
          out_d.cnt_status = sub_d[1:0];
          out_d.colour     = 3'b100;
        end else begin
          out_d.rst_address = 1'b1;
        end
      end
      UPDATE: begin
        out_d.update_head       = (sub_d == 3'd0);
        out_d.ld_head_into_prev = (sub_d != 3'd0);
      end
      SHIFT: begin
        if (!tail) begin
          out_d.ld_q_into_curr    = (sub_d == 3'd1);
          out_d.ld_prev_into_q    = (sub_d == 3'd2);
          out_d.ld_curr_into_prev = (sub_d == 3'd3);
          out_d.inc_address       = (sub_d == 3'd3);
        end else begin
          out_d.rst_address = 1'b1;
        end
      end
      EAT:     out_d.waiting = 1'b1;
      DEAD:    out_d.dead    = 1'b1;
      default: out_d = '0;
    endcase
  end

  assign bus.waiting           = out_q.waiting;
  assign bus.ld_head           = out_q.ld_head;
  assign bus.ld_q_def          = out_q.ld_q_def;
  assign bus.inc_address       = out_q.inc_address;
  assign bus.rst_address       = out_q.rst_address;
  assign bus.draw_q            = out_q.draw_q;
  assign bus.draw_curr         = 1'b0;
  assign bus.update_head       = out_q.update_head;
  assign bus.ld_head_into_prev = out_q.ld_head_into_prev;
  assign bus.ld_q_into_curr    = out_q.ld_q_into_curr;
  assign bus.ld_prev_into_q    = out_q.ld_prev_into_q;
  assign bus.ld_curr_into_prev = out_q.ld_curr_into_prev;
  assign bus.food_en           = out_q.food_en;
  assign bus.cnt_status        = out_q.cnt_status;
  assign bus.colour            = out_q.colour;
  assign bus.dead              = out_q.dead;
  assign bus.dir               = dir_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_control.sv
// ============================================================================
// tb_snake_control : directed self-checking bench for snake_control
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_snake_control;

  localparam logic [12:0] M_WAIT = 13'h1000;
  localparam logic [12:0] M_LDH  = 13'h0800;
  localparam logic [12:0] M_LQD  = 13'h0400;
  localparam logic [12:0] M_INC  = 13'h0200;
  localparam logic [12:0] M_RSTA = 13'h0100;
  localparam logic [12:0] M_DRWQ = 13'h0080;
  localparam logic [12:0] M_UPD  = 13'h0020;
  localparam logic [12:0] M_FOOD = 13'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_control_if bus ();

  snake_control #(
    .FRAME_CYCLES (10),
    .CNT_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [12:0] strobes();
    return {bus.waiting, bus.ld_head, bus.ld_q_def, bus.inc_address, bus.rst_address,
            bus.draw_q, bus.draw_curr, bus.update_head, bus.ld_head_into_prev,
            bus.ld_q_into_curr, bus.ld_prev_into_q, bus.ld_curr_into_prev, bus.food_en};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_for(input logic [12:0] mask, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ((strobes() & mask) != 13'h0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic hold_button(input int which);
    bus.btn_up    = (which == 0) || (which == 4);
    bus.btn_down  = (which == 1);
    bus.btn_left  = (which == 2) || (which == 4);
    bus.btn_right = (which == 3);
    repeat (220) step();
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    step();
  endtask

  initial begin
    int bad, n, w, p, q, ndraw, nfood;
    bit seen;
    rst = 1'b0;
    bus.start = 1'b0;
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    bus.isDead = 1'b0;
    bus.length = 11'd6;
    repeat (3) step();
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_dir", 32'(bus.dir), 32'h4);
    check("reset_colour", 32'(bus.colour), 32'd0);
    check("reset_cnt_status", 32'(bus.cnt_status), 32'd0);
    check("reset_dead", 32'(bus.dead), 32'd0);

    // Bring-up sequence with length 6.
    rst = 1'b1;
    step();
    bus.start = 1'b1;
    wait_for(M_LDH, "ld_head_seen");
    check("init_head", 32'(strobes()), 32'(M_LDH | M_RSTA));
    step();
    n = 0;
    while (strobes() == (M_LQD | M_INC) && n < 20) begin
      n++;
      step();
    end
    check("init_fill_cycles", n, 6);
    check("init_end", 32'(strobes()), 32'(M_RSTA));

    bad = 0; ndraw = 0; nfood = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (strobes() != 13'h0) bad++;
      for (int k = 0; k < 4; k++) begin
        step();
        if (strobes() != (M_DRWQ | ((k == 3) ? M_INC : 13'h0)) ||
            bus.cnt_status != 2'(k) || bus.colour != 3'b010) bad++;
        if (bus.draw_q) ndraw++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (strobes() != M_FOOD || bus.cnt_status != 2'(k) || bus.colour != 3'b100) bad++;
      if (bus.food_en) nfood++;
    end
    step();
    if (strobes() != M_RSTA) bad++;
    check("draw_seq_errors", bad, 0);
    check("draw_q_cycles", ndraw, 24);
    check("food_cycles", nfood, 4);
    step();
    check("wait_quiet", 32'(strobes()), 32'd0);

    // Frame period between update_head pulses.
    wait_for(M_UPD, "update_seen");
    n = 0; w = 0; p = 0;
    do begin
      step();
      n++;
      if (bus.waiting) w++;
      if (bus.ld_prev_into_q) p++;
    end while (!bus.update_head && n < 300);
    check("frame_period", n, 104);
    check("waiting_per_move", w, 1);
    check("shift_pulses_len6", p, 6);

    // Direction decode.
    bus.start = 1'b0;
    hold_button(1);
    check("dir_down_rejected", 32'(bus.dir), 32'h4);
    hold_button(2);
    check("dir_left", 32'(bus.dir), 32'h0);
    hold_button(3);
    check("dir_right_rejected", 32'(bus.dir), 32'h0);
    hold_button(4);
    check("dir_up_priority", 32'(bus.dir), 32'h4);

    // Growth at EAT is drawn in the same move and shifted from the next.
    wait_for(M_WAIT, "eat_seen");
    bus.length = 11'd7;
    n = 0; ndraw = 0;
    do begin
      step();
      n++;
      if (bus.draw_q) ndraw++;
    end while (!bus.food_en && n < 300);
    check("draw_q_after_growth", ndraw, 28);
    n = 0; p = 0; ndraw = 0;
    do begin
      step();
      n++;
      if (bus.ld_prev_into_q) p++;
      if (bus.draw_q && bus.colour == 3'b000) ndraw++;
    end while (!bus.waiting && n < 300);
    check("erase_after_growth", ndraw, 28);
    check("shift_pulses_len7", p, 7);

    // Collision in the third shift segment.
    wait_for(M_UPD, "update_before_dead");
    q = 0;
    for (int k = 0; k < 100 && q < 3; k++) begin
      step();
      if (bus.ld_q_into_curr) q++;
    end
    check("third_segment_reached", q, 3);
    bus.isDead = 1'b1;
    step();
    check("dead_set", 32'(bus.dead), 32'd1);
    check("dead_quiet", 32'(strobes()), 32'd0);
    bus.isDead = 1'b0;
    bus.start = 1'b1;
    bus.btn_left = 1'b1;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (!bus.dead || strobes() != 13'h0 || bus.dir != 3'b100) bad++;
    end
    bus.btn_left = 1'b0;
    check("dead_hold_errors", bad, 0);

    // Asynchronous reset in the middle of ERASE.
    rst = 1'b0;
    step();
    check("dead_cleared", 32'(bus.dead), 32'd0);
    bus.btn_right = 1'b1;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (bus.draw_q && bus.colour == 3'b000) begin
        seen = 1'b1;
        break;
      end
    end
    check("erase_reached", {31'd0, seen}, 32'd1);
    bus.btn_right = 1'b0;
    check("dir_right_pre_reset", 32'(bus.dir), 32'h1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("async_reset_strobes", 32'(strobes()), 32'd0);
    check("async_reset_dir", 32'(bus.dir), 32'h4);
    check("async_reset_colour", 32'(bus.colour), 32'd0);
    step();
    bus.start = 1'b0;
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (strobes() != 13'h0 || bus.dead) bad++;
    end
    check("idle_hold_errors", bad, 0);
    bus.start = 1'b1;
    step();
    wait_for(M_LDH, "restart_ld_head");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
